// File: rtl/decode_scoreboard.sv
// decode_scoreboard: decode-stage register file with per-register pending-write counters, WB bypass and registered issue
module decode_scoreboard #(
   parameter int DATA_WIDTH = 16,
   parameter int NUM_REGS   = 16,
   parameter int IDX_WIDTH  = 4,
   parameter int PEND_WIDTH = 2
) (
   input  logic                  I_CLOCK,
   input  logic                  I_RESET,
   input  logic                  I_Valid,
   input  logic                  I_Src1En,
   input  logic [IDX_WIDTH-1:0]  I_Src1Idx,
   input  logic                  I_Src2En,
   input  logic [IDX_WIDTH-1:0]  I_Src2Idx,
   input  logic                  I_DestEn,
   input  logic [IDX_WIDTH-1:0]  I_DestIdx,
   input  logic                  I_Stall,
   input  logic                  I_WbEnable,
   input  logic [IDX_WIDTH-1:0]  I_WbIdx,
   input  logic [DATA_WIDTH-1:0] I_WbData,
   output logic                  O_DepStall,
   output logic                  O_Ready,
   output logic                  O_Valid,
   output logic [DATA_WIDTH-1:0] O_Src1Value,
   output logic [DATA_WIDTH-1:0] O_Src2Value,
   output logic                  O_DestEn,
   output logic [IDX_WIDTH-1:0]  O_DestIdx,
   output logic [2:0]            O_CondCode,
   output logic                  O_Error
);
   localparam logic [PEND_WIDTH-1:0] MAX = '1;
   localparam logic [PEND_WIDTH-1:0] ONE = PEND_WIDTH'(1);
   logic [DATA_WIDTH-1:0] r_rf [NUM_REGS];
   logic [PEND_WIDTH-1:0] r_pend [NUM_REGS];
   logic                  r_valid, r_dest_en, r_error;
   logic [DATA_WIDTH-1:0] r_src1, r_src2;
   logic [IDX_WIDTH-1:0]  r_dest_idx;
   logic [2:0]            r_cc;
   logic [PEND_WIDTH-1:0] w_p1, w_p2, w_pd;
   logic [DATA_WIDTH-1:0] w_v1, w_v2;
   logic [NUM_REGS-1:0]   w_inc, w_dec;
   logic                  w_hit1, w_hit2, w_hitd, w_haz1, w_haz2, w_ovf, w_issue, w_err;

   assign w_hit1     = I_WbEnable & (I_WbIdx == I_Src1Idx);
   assign w_hit2     = I_WbEnable & (I_WbIdx == I_Src2Idx);
   assign w_hitd     = I_WbEnable & (I_WbIdx == I_DestIdx);
   assign w_haz1     = I_Src1En & (w_p1 != '0) & !((w_p1 == ONE) & w_hit1);
   assign w_haz2     = I_Src2En & (w_p2 != '0) & !((w_p2 == ONE) & w_hit2);
   assign w_ovf      = I_DestEn & (w_pd == MAX) & !w_hitd;
   assign O_DepStall = I_Valid & (w_haz1 | w_haz2 | w_ovf);
   assign O_Ready    = I_Valid & !O_DepStall & !I_Stall;
   assign w_issue    = O_Ready;

   // Look up counters and bypassed operands; indices beyond NUM_REGS match nothing and read as zero
   always_comb begin
      w_p1 = '0;
      w_p2 = '0;
      w_pd = '0;
      w_v1 = '0;
      w_v2 = '0;
      w_inc = '0;
      w_dec = '0;
      w_err = 1'b0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (I_Src1Idx == IDX_WIDTH'(i)) begin
            w_p1 = r_pend[i];
            w_v1 = I_Src1En ? (w_hit1 ? I_WbData : r_rf[i]) : '0;
         end
         if (I_Src2Idx == IDX_WIDTH'(i)) begin
            w_p2 = r_pend[i];
            w_v2 = I_Src2En ? (w_hit2 ? I_WbData : r_rf[i]) : '0;
         end
         if (I_DestIdx == IDX_WIDTH'(i)) w_pd = r_pend[i];
         w_inc[i] = w_issue & I_DestEn & (I_DestIdx == IDX_WIDTH'(i));
         w_dec[i] = I_WbEnable & (I_WbIdx == IDX_WIDTH'(i));
         w_err = w_err | (w_dec[i] & !w_inc[i] & (r_pend[i] == '0));
      end
   end

   // Register file, pending counters, condition code and sticky unmatched-writeback flag
   always_ff @(posedge I_CLOCK or posedge I_RESET) begin
      if (I_RESET) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            r_rf[i]   <= '0;
            r_pend[i] <= '0;
         end
         r_cc    <= 3'b000;
         r_error <= 1'b0;
      end else begin
         for (int i = 0; i < NUM_REGS; i++) begin
            if (w_dec[i]) r_rf[i] <= I_WbData;
            if (w_inc[i] && !w_dec[i]) r_pend[i] <= r_pend[i] + ONE;
            else if (w_dec[i] && !w_inc[i] && r_pend[i] != '0) r_pend[i] <= r_pend[i] - ONE;
         end
         if (I_WbEnable) r_cc <= I_WbData[DATA_WIDTH-1] ? 3'b100 : (I_WbData == '0 ? 3'b010 : 3'b001);
         if (w_err) r_error <= 1'b1;
      end
   end

   // Issue register toward execute; a stall freezes everything, otherwise a bubble only clears valid
   always_ff @(posedge I_CLOCK or posedge I_RESET) begin
      if (I_RESET) begin
         r_valid    <= 1'b0;
         r_src1     <= '0;
         r_src2     <= '0;
         r_dest_en  <= 1'b0;
         r_dest_idx <= '0;
      end else if (w_issue) begin
         r_valid    <= 1'b1;
         r_src1     <= w_v1;
         r_src2     <= w_v2;
         r_dest_en  <= I_DestEn;
         r_dest_idx <= I_DestIdx;
      end else if (!I_Stall) begin
         r_valid <= 1'b0;
      end
   end

   assign O_Valid     = r_valid;
   assign O_Src1Value = r_src1;
   assign O_Src2Value = r_src2;
   assign O_DestEn    = r_dest_en;
   assign O_DestIdx   = r_dest_idx;
   assign O_CondCode  = r_cc;
   assign O_Error     = r_error;
endmodule

// File: tb/tb_decode_scoreboard.sv
// tb_decode_scoreboard: directed self-checking bench for decode_scoreboard
module tb_decode_scoreboard;
   logic        clk, rst;
   logic        i_valid, i_s1en, i_s2en, i_den, i_stall, i_wben;
   logic [3:0]  i_s1, i_s2, i_d, i_wbidx;
   logic [15:0] i_wbdata;
   logic        o_depstall, o_ready, o_valid, o_desten, o_error;
   logic [15:0] o_src1, o_src2;
   logic [3:0]  o_destidx;
   logic [2:0]  o_cc;
   int          n_checks, n_fail;

   decode_scoreboard dut (
      .I_CLOCK(clk), .I_RESET(rst), .I_Valid(i_valid),
      .I_Src1En(i_s1en), .I_Src1Idx(i_s1), .I_Src2En(i_s2en), .I_Src2Idx(i_s2),
      .I_DestEn(i_den), .I_DestIdx(i_d), .I_Stall(i_stall),
      .I_WbEnable(i_wben), .I_WbIdx(i_wbidx), .I_WbData(i_wbdata),
      .O_DepStall(o_depstall), .O_Ready(o_ready), .O_Valid(o_valid),
      .O_Src1Value(o_src1), .O_Src2Value(o_src2), .O_DestEn(o_desten),
      .O_DestIdx(o_destidx), .O_CondCode(o_cc), .O_Error(o_error)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic instr(input logic v, input logic s1en, input logic [3:0] s1,
                        input logic s2en, input logic [3:0] s2, input logic den, input logic [3:0] d);
      i_valid = v; i_s1en = s1en; i_s1 = s1; i_s2en = s2en; i_s2 = s2; i_den = den; i_d = d;
   endtask

   task automatic wb(input logic en, input logic [3:0] idx, input logic [15:0] data);
      i_wben = en; i_wbidx = idx; i_wbdata = data;
   endtask

   initial begin
      n_checks = 0;
      n_fail = 0;
      rst = 1'b1;
      i_stall = 1'b0;
      instr(0, 0, 0, 0, 0, 0, 0);
      wb(0, 0, 0);
      repeat (2) step();
      chk("rst_valid", o_valid, 0);
      chk("rst_src1", o_src1, 0);
      chk("rst_src2", o_src2, 0);
      chk("rst_desten", o_desten, 0);
      chk("rst_destidx", o_destidx, 0);
      chk("rst_cc", o_cc, 0);
      chk("rst_error", o_error, 0);
      rst = 1'b0;
      step();
      // 1: plain issue from zeroed RF
      instr(1, 1, 3, 1, 4, 0, 0);
      #1;
      chk("t1_depstall", o_depstall, 0);
      chk("t1_ready", o_ready, 1);
      step();
      chk("t1_valid", o_valid, 1);
      chk("t1_src1", o_src1, 0);
      chk("t1_src2", o_src2, 0);
      chk("t1_cc", o_cc, 3'b000);
      // 2: RAW hazard on R2 resolved by same-cycle bypass
      instr(1, 0, 0, 0, 0, 1, 2);
      #1;
      chk("t2_dest_ready", o_ready, 1);
      step();
      chk("t2_desten", o_desten, 1);
      chk("t2_destidx", o_destidx, 2);
      instr(1, 1, 2, 0, 0, 0, 0);
      #1;
      chk("t2_stall_a", o_depstall, 1);
      chk("t2_noready", o_ready, 0);
      step();
      chk("t2_bubble", o_valid, 0);
      chk("t2_stall_b", o_depstall, 1);
      step();
      wb(1, 2, 16'h0005);
      #1;
      chk("t2_bypass_nostall", o_depstall, 0);
      chk("t2_bypass_ready", o_ready, 1);
      step();
      chk("t2_bypass_valid", o_valid, 1);
      chk("t2_bypass_src1", o_src1, 16'h0005);
      chk("t2_cc_pos", o_cc, 3'b001);
      // 3: counter saturation on R1
      wb(0, 0, 0);
      instr(1, 0, 0, 0, 0, 1, 1);
      for (int k = 0; k < 3; k++) begin
         #1;
         chk("t3_waw_ready", o_ready, 1);
         step();
      end
      chk("t3_full_stall", o_depstall, 1);
      step();
      chk("t3_full_bubble", o_valid, 0);
      wb(1, 1, 16'h0007);
      #1;
      chk("t3_full_wb_ready", o_ready, 1);
      step();
      wb(0, 0, 0);
      #1;
      chk("t3_still_full", o_depstall, 1);
      instr(0, 0, 0, 0, 0, 0, 0);
      wb(1, 1, 16'h0000);
      repeat (3) step();
      wb(0, 0, 0);
      chk("t3_no_error", o_error, 0);
      chk("t3_cc_zero", o_cc, 3'b010);
      // 4: downstream stall freezes the output register
      instr(1, 1, 2, 1, 1, 0, 0);
      step();
      chk("t4_valid", o_valid, 1);
      chk("t4_src1", o_src1, 16'h0005);
      chk("t4_src2", o_src2, 16'h0000);
      instr(1, 1, 3, 0, 0, 0, 0);
      i_stall = 1'b1;
      #1;
      chk("t4_stall_noready", o_ready, 0);
      for (int k = 0; k < 3; k++) begin
         step();
         chk("t4_hold_valid", o_valid, 1);
         chk("t4_hold_src1", o_src1, 16'h0005);
      end
      i_stall = 1'b0;
      instr(0, 0, 0, 0, 0, 0, 0);
      step();
      chk("t4_release_valid", o_valid, 0);
      chk("t4_release_src1", o_src1, 16'h0005);
      // 5: unmatched writeback sets sticky error, async reset clears it
      wb(1, 7, 16'hFFFF);
      step();
      chk("t5_error", o_error, 1);
      chk("t5_cc_neg", o_cc, 3'b100);
      wb(0, 0, 0);
      instr(1, 1, 7, 0, 0, 0, 0);
      #1;
      chk("t5_r7_nostall", o_depstall, 0);
      step();
      chk("t5_r7_src1", o_src1, 16'hFFFF);
      chk("t5_error_sticky", o_error, 1);
      instr(0, 0, 0, 0, 0, 0, 0);
      rst = 1'b1;
      #1;
      chk("t5_async_error", o_error, 0);
      chk("t5_async_valid", o_valid, 0);
      chk("t5_async_cc", o_cc, 3'b000);
      rst = 1'b0;
      step();
      // 6: reader of R5 with two writes pending
      instr(1, 0, 0, 0, 0, 1, 5);
      for (int k = 0; k < 2; k++) begin
         #1;
         chk("t6_dest_ready", o_ready, 1);
         step();
      end
      instr(1, 1, 5, 0, 0, 0, 0);
      wb(1, 5, 16'h0009);
      #1;
      chk("t6_stall_pend2", o_depstall, 1);
      step();
      chk("t6_bubble", o_valid, 0);
      wb(1, 5, 16'h000A);
      #1;
      chk("t6_nostall_pend1", o_depstall, 0);
      chk("t6_ready", o_ready, 1);
      step();
      chk("t6_valid", o_valid, 1);
      chk("t6_src1", o_src1, 16'h000A);
      chk("t6_error", o_error, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/decode_scoreboard.md
Name: decode_scoreboard

Overview:
Parametrised decode-stage register file with a counting scoreboard. It replaces the single valid bit per register with a per-register pending-write counter, so several in-flight writes to the same register are tracked. It adds a same-cycle writeback bypass, a registered one-cycle issue path with downstream back-pressure, and a sticky error flag for unmatched writebacks. It sits between fetch and execute, and takes writebacks from the WB stage.

Parameters:
DATA_WIDTH, 16, register and operand width in bits.
NUM_REGS, 16, number of architectural registers.
IDX_WIDTH, 4, register index width; NUM_REGS <= 2**IDX_WIDTH.
PEND_WIDTH, 2, pending-counter width; max in-flight writes per register = 2**PEND_WIDTH-1.

Ports:
I_CLOCK  in  1  clock, all state on rising edge
I_RESET  in  1  asynchronous, active-high reset
I_Valid  in  1  fetch presents an instruction this cycle
I_Src1En  in  1  instruction reads source 1
I_Src1Idx  in  IDX_WIDTH  source 1 register index
I_Src2En  in  1  instruction reads source 2
I_Src2Idx  in  IDX_WIDTH  source 2 register index
I_DestEn  in  1  instruction writes a destination
I_DestIdx  in  IDX_WIDTH  destination register index
I_Stall  in  1  execute cannot accept; hold the output register
I_WbEnable  in  1  writeback valid
I_WbIdx  in  IDX_WIDTH  writeback register index
I_WbData  in  DATA_WIDTH  writeback data
O_DepStall  out  1  combinational; hazard blocks the current instruction
O_Ready  out  1  combinational; instruction is accepted this cycle
O_Valid  out  1  registered; issued instruction valid toward execute
O_Src1Value  out  DATA_WIDTH  registered source 1 operand
O_Src2Value  out  DATA_WIDTH  registered source 2 operand
O_DestEn  out  1  registered destination enable
O_DestIdx  out  IDX_WIDTH  registered destination index
O_CondCode  out  3  condition code {N,Z,P} from the last writeback
O_Error  out  1  sticky; writeback arrived for a register with pending = 0

Behaviour:
- Clock and reset: one clock, I_CLOCK. Reset is asynchronous and active-high on I_RESET.
- Reset state: all registers = 0, all pending counters = 0, O_Valid = 0, operand outputs = 0, O_DestEn = 0, O_DestIdx = 0, O_CondCode = 3'b000, O_Error = 0. Deasserting reset mid-stream discards the instruction in flight; the first post-reset cycle behaves like a fresh cycle.
- Bypass condition: wbhit(r) = I_WbEnable & (I_WbIdx == r).
- Source hazard for index s: srcEn & pending[s] != 0 & !(pending[s] == 1 & wbhit(s)).
- Destination overflow: I_DestEn & pending[d] == MAX & !wbhit(d), where MAX = 2**PEND_WIDTH-1.
- O_DepStall = I_Valid & (src1 hazard | src2 hazard | dest overflow). Write-after-write to the same destination is not a hazard; the counter tracks it.
- O_Ready = I_Valid & !O_DepStall & !I_Stall. Issue occurs when O_Ready = 1.
- On issue, at the next rising edge:
  - O_Valid <= 1.
  - Each operand <= wbhit(idx) ? I_WbData : RF[idx]. Disabled sources load 0.
  - O_DestEn <= I_DestEn; O_DestIdx <= I_DestIdx.
- No issue and !I_Stall: O_Valid <= 0; other outputs hold.
- I_Stall = 1: all output registers hold, whatever the input.
- Latency: one cycle from accept to O_Valid.
- Writeback, every edge with I_WbEnable:
  - RF[I_WbIdx] <= I_WbData.
  - O_CondCode <= 3'b100 if the data is negative (signed), 3'b010 if zero, 3'b001 if positive.
- Pending counter update per register r. Let inc = issue & I_DestEn & I_DestIdx == r, and dec = wbhit(r):
  - inc & !dec: pending +1.
  - dec & !inc: pending -1.
  - Both: unchanged.
  - dec with pending = 0 and no inc: counter stays 0 and O_Error <= 1. O_Error stays set until reset.
- An index >= NUM_REGS reads 0 and is ignored for writes and counters.
- Reads and writes of distinct registers in the same cycle are independent.

Test Plan:
1. Reset, then issue src1 = R3, src2 = R4, no dest, with RF = 0 -> O_DepStall = 0, O_Ready = 1; next cycle O_Valid = 1, operands 0/0, O_CondCode = 000.
2. Issue dest R2 (pending[2] = 1), then an instruction reading R2 -> O_DepStall = 1 until the cycle WB R2 = 16'h0005 arrives. That cycle O_Ready = 1 and O_Src1Value = 5 the next cycle (bypass); O_CondCode = 001.
3. Issue three writes to R1 with PEND_WIDTH = 2 -> pending = 3; a fourth write to R1 stalls. It is accepted in the same cycle a WB to R1 arrives, leaving pending = 3.
4. Hold I_Stall = 1 for 3 cycles after an issue -> O_Valid and the operands are frozen and O_Ready = 0. Release -> O_Valid drops to 0 the next cycle if I_Valid = 0.
5. WB to R7 with pending[7] = 0, data 16'hFFFF -> O_Error = 1 and stays 1, pending[7] = 0, O_CondCode = 100. Assert I_RESET asynchronously -> O_Error = 0 immediately.
6. Reader of R5 (pending = 2) with a WB to R5 in the same cycle -> still O_DepStall = 1, pending[5] becomes 1. A second WB clears the stall.
